// File: rtl/uart_bridge_master.sv
// Avalon-MM master that polls a UART status register and shuttles bytes between
// CPU-side valid/ready streams and the UART rxdata/txdata registers.
module uart_bridge_master #(
  parameter logic [4:0] ADDR_RXDATA = 5'h00,
  parameter logic [4:0] ADDR_TXDATA = 5'h04,
  parameter logic [4:0] ADDR_STATUS = 5'h08,
  parameter int         POLL_GAP    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic [4:0] avm_address,
  output logic       avm_read,
  output logic       avm_write,
  output logic [7:0] avm_writedata,
  output logic       avm_byteenable,
  output logic       avm_burstcount,
  output logic       avm_debugaccess,
  input  logic       avm_waitrequest,
  input  logic [7:0] avm_readdata,
  input  logic       avm_readdatavalid
);

  localparam logic [2:0] GAP   = 3'd0;
  localparam logic [2:0] ST_RD = 3'd1;
  localparam logic [2:0] ST_WT = 3'd2;
  localparam logic [2:0] RX_RD = 3'd3;
  localparam logic [2:0] RX_WT = 3'd4;
  localparam logic [2:0] TX_WR = 3'd5;

  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  logic [2:0]  state;
  logic [15:0] gap_cnt;
  logic        snap_trdy;
  logic        tx_full;
  logic [7:0]  tx_byte;
  logic [7:0]  fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic tx_load;
  logic tx_pending;
  logic tx_free;
  logic push;
  logic pop;

  // A byte accepted in the same cycle as a decision still counts as pending.
  assign tx_load    = tx_valid && !tx_full;
  assign tx_pending = tx_full || tx_load;
  assign tx_free    = (state == TX_WR) && !avm_waitrequest;
  assign push       = (state == RX_WT) && avm_readdatavalid;
  assign pop        = (count != 2'd0) && rx_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= GAP;
      gap_cnt    <= '0;
      snap_trdy  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      case (state)
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= ST_RD;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        ST_RD: if (!avm_waitrequest) state <= ST_WT;
        ST_WT: begin
          if (avm_readdatavalid) begin
            snap_trdy <= avm_readdata[6];
            if (avm_readdata[3] || (avm_readdata[7] && count == 2'd2)) rx_overrun <= 1'b1;
            if (avm_readdata[7] && count != 2'd2) begin
              state <= RX_RD;
            end else if (avm_readdata[6] && tx_pending) begin
              state <= TX_WR;
            end else begin
              state   <= GAP;
              gap_cnt <= '0;
            end
          end
        end
        RX_RD: if (!avm_waitrequest) state <= RX_WT;
        RX_WT: if (avm_readdatavalid) state <= (snap_trdy && tx_pending) ? TX_WR : ST_RD;
        TX_WR: if (!avm_waitrequest) state <= ST_RD;
        default: state <= GAP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_full <= 1'b0;
      tx_byte <= '0;
    end else if (tx_load) begin
      tx_full <= 1'b1;
      tx_byte <= tx_data;
    end else if (tx_free) begin
      tx_full <= 1'b0;
    end
  end

  // Push is only reached when the decision saw space, so it never overflows.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= avm_readdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    avm_address = '0;
    case (state)
      ST_RD:   avm_address = ADDR_STATUS;
      RX_RD:   avm_address = ADDR_RXDATA;
      TX_WR:   avm_address = ADDR_TXDATA;
      default: avm_address = '0;
    endcase
  end

  assign avm_read        = (state == ST_RD) || (state == RX_RD);
  assign avm_write       = (state == TX_WR);
  assign avm_writedata   = (state == TX_WR) ? tx_byte : 8'h00;
  assign avm_byteenable  = 1'b1;
  assign avm_burstcount  = 1'b1;
  assign avm_debugaccess = 1'b0;

  assign tx_ready = !tx_full;
  assign rx_valid = (count != 2'd0);
  assign rx_data  = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_uart_bridge_master.sv
// Bench for uart_bridge_master: a behavioural UART slave plus byte-order scoreboards
// for the CPU-side tx and rx streams.
module tb_uart_bridge_master;

  localparam int POLL_GAP = 16;

  typedef struct {
    bit         is_write;
    logic [4:0] addr;
    logic [7:0] data;
    int         hold;
    bit         stable;
    int         start_cyc;
    int         acc_cyc;
    logic       txr_before;
    logic       txr_after;
  } cmd_t;

  logic       clk;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic [4:0] avm_address;
  logic       avm_read;
  logic       avm_write;
  logic [7:0] avm_writedata;
  logic       avm_byteenable;
  logic       avm_burstcount;
  logic       avm_debugaccess;
  logic       waitreq;
  logic [7:0] rd_r;
  logic       rdv_r;
  logic [7:0] spur_data;
  logic       spur_rdv;
  logic [7:0] bus_rd;
  logic       bus_rdv;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   both_hi = 0;
  bit   trdy_en = 1;
  bit   roe_en = 0;
  bit   rand_bus = 0;
  int   ws_rd = 0;
  int   ws_wr = 0;
  int   rdv_delay = 0;

  logic [7:0] uart_rxq [$];
  cmd_t       log_q [$];
  cmd_t       resp_e;
  int         resp_ws;
  int         resp_dly;
  bit         resp_ab;

  assign bus_rd  = spur_rdv ? spur_data : rd_r;
  assign bus_rdv = rdv_r | spur_rdv;

  uart_bridge_master #(.POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .reset_n(reset_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_burstcount(avm_burstcount), .avm_debugaccess(avm_debugaccess),
    .avm_waitrequest(waitreq), .avm_readdata(bus_rd), .avm_readdatavalid(bus_rdv)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (avm_read && avm_write) both_hi = 1;

  function automatic logic [7:0] status_fn();
    return {(uart_rxq.size() != 0), trdy_en, 2'b00, roe_en, 3'b000};
  endfunction

  // UART slave: waitrequest stretching, delayed readdatavalid, command log.
  initial begin
    waitreq = 0; rdv_r = 0; rd_r = 0;
    @(negedge clk);
    forever begin
      if (reset_n && (avm_read || avm_write)) begin
        resp_e.is_write = avm_write;
        resp_e.addr = avm_address;
        resp_e.data = avm_writedata;
        resp_e.hold = 1;
        resp_e.stable = 1;
        resp_e.start_cyc = cyc;
        resp_ws = rand_bus ? int'($urandom_range(0, 2)) : (avm_write ? ws_wr : ws_rd);
        resp_ab = 0;
        for (int k = 0; k < resp_ws; k++) begin
          waitreq = 1;
          @(negedge clk);
          if (!reset_n) begin resp_ab = 1; break; end
          resp_e.hold++;
          if (avm_address !== resp_e.addr || avm_writedata !== resp_e.data ||
              avm_write !== resp_e.is_write || avm_read !== !resp_e.is_write)
            resp_e.stable = 0;
        end
        resp_e.txr_before = tx_ready;
        waitreq = 0;
        @(negedge clk);
        if (!resp_ab) begin
          resp_e.acc_cyc = cyc;
          resp_e.txr_after = tx_ready;
          if (!resp_e.is_write) begin
            if (resp_e.addr == 5'h08) resp_e.data = status_fn();
            else if (uart_rxq.size() > 0) resp_e.data = uart_rxq.pop_front();
            else resp_e.data = 8'h00;
            resp_dly = rand_bus ? int'($urandom_range(0, 3)) : rdv_delay;
            repeat (resp_dly) @(negedge clk);
            rd_r = resp_e.data; rdv_r = 1;
            @(negedge clk);
            rdv_r = 0;
          end
          log_q.push_back(resp_e);
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; tx_valid = 0; rx_ready = 0;
    repeat (8) @(negedge clk);
    uart_rxq.delete(); log_q.delete();
    trdy_en = 1; roe_en = 0; rand_bus = 0; ws_rd = 0; ws_wr = 0; rdv_delay = 0;
    reset_n = 1;
  endtask

  task automatic test_reset();
    int first;
    repeat (3) @(negedge clk);
    checks += 8;
    if (avm_read !== 1'b0) begin failures++; $display("FAIL rst_read got=%b exp=0", avm_read); end
    if (avm_write !== 1'b0) begin failures++; $display("FAIL rst_write got=%b exp=0", avm_write); end
    if (avm_address !== 5'h00) begin failures++; $display("FAIL rst_addr got=%h exp=00", avm_address); end
    if (avm_writedata !== 8'h00) begin failures++; $display("FAIL rst_wdata got=%h exp=00", avm_writedata); end
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL rst_tx_ready got=%b exp=1", tx_ready); end
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
    if (rx_data !== 8'h00) begin failures++; $display("FAIL rst_rx_data got=%h exp=00", rx_data); end
    if (rx_overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%b exp=0", rx_overrun); end
    reset_n = 1;
    first = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (avm_read) begin first = i; break; end
    end
    checks += 4;
    if (first != POLL_GAP) begin failures++; $display("FAIL first_poll_cycle got=%0d exp=%0d", first, POLL_GAP); end
    if (avm_address !== 5'h08) begin failures++; $display("FAIL first_poll_addr got=%h exp=08", avm_address); end
    if (avm_byteenable !== 1'b1 || avm_burstcount !== 1'b1) begin
      failures++; $display("FAIL be_burst got=%b%b exp=11", avm_byteenable, avm_burstcount); end
    if (avm_debugaccess !== 1'b0) begin failures++; $display("FAIL debugaccess got=%b exp=0", avm_debugaccess); end
  endtask

  task automatic test_tx();
    int wi;
    do_reset();
    ws_wr = 3;
    checks++;
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL tx_ready_idle got=%b exp=1", tx_ready); end
    tx_data = 8'h41; tx_valid = 1;
    @(negedge clk);
    tx_valid = 0; tx_data = 8'h00;
    checks++;
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL tx_ready_after_load got=%b exp=0", tx_ready); end
    for (int i = 0; i < 100 && log_q.size() < 2; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (log_q.size() < 2) begin
      failures++; $display("FAIL tx_log_size got=%0d exp>=2", log_q.size());
    end else begin
      wi = 1;
      checks += 7;
      if (log_q[0].data !== 8'h40) begin failures++; $display("FAIL tx_status got=%h exp=40", log_q[0].data); end
      if (!log_q[wi].is_write || log_q[wi].addr !== 5'h04) begin
        failures++; $display("FAIL tx_wr_addr got=%b/%h exp=1/04", log_q[wi].is_write, log_q[wi].addr); end
      if (log_q[wi].data !== 8'h41) begin failures++; $display("FAIL tx_wr_data got=%h exp=41", log_q[wi].data); end
      if (log_q[wi].hold != 4) begin failures++; $display("FAIL tx_wr_hold got=%0d exp=4", log_q[wi].hold); end
      if (!log_q[wi].stable) begin failures++; $display("FAIL tx_wr_stable got=0 exp=1"); end
      if (log_q[wi].txr_before !== 1'b0) begin failures++; $display("FAIL tx_ready_pre got=%b exp=0", log_q[wi].txr_before); end
      if (log_q[wi].txr_after !== 1'b1) begin failures++; $display("FAIL tx_ready_post got=%b exp=1", log_q[wi].txr_after); end
    end
  endtask

  task automatic test_rx();
    logic [7:0] exp [3] = '{8'h5A, 8'hB1, 8'hC2};
    logic [7:0] got [$];
    int n0;
    do_reset();
    trdy_en = 0;
    foreach (exp[i]) uart_rxq.push_back(exp[i]);
    for (int i = 0; i < 100 && !rx_valid; i++) @(negedge clk);
    checks += 2;
    if (rx_valid !== 1'b1) begin failures++; $display("FAIL rx_valid got=%b exp=1", rx_valid); end
    if (rx_data !== 8'h5A) begin failures++; $display("FAIL rx_first got=%h exp=5A", rx_data); end
    for (int i = 0; i < 200 && !rx_overrun; i++) @(negedge clk);
    repeat (60) @(negedge clk);
    n0 = 0;
    foreach (log_q[i]) if (!log_q[i].is_write && log_q[i].addr == 5'h00) n0++;
    checks += 4;
    if (rx_overrun !== 1'b1) begin failures++; $display("FAIL rx_overrun got=%b exp=1", rx_overrun); end
    if (n0 != 2) begin failures++; $display("FAIL rx_reads got=%0d exp=2", n0); end
    if (uart_rxq.size() != 1) begin failures++; $display("FAIL rx_left got=%0d exp=1", uart_rxq.size()); end
    if (rx_data !== 8'h5A) begin failures++; $display("FAIL rx_head_full got=%h exp=5A", rx_data); end
    rx_ready = 1;
    for (int i = 0; i < 300 && got.size() < 3; i++) begin
      if (rx_valid) got.push_back(rx_data);
      if (got.size() < 3) @(negedge clk);
    end
    @(negedge clk);
    rx_ready = 0;
    checks++;
    if (got.size() != 3) begin failures++; $display("FAIL rx_pop_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin failures++; $display("FAIL rx_order[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_both();
    do_reset();
    uart_rxq.push_back(8'h7E);
    tx_data = 8'h33; tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
    for (int i = 0; i < 120 && log_q.size() < 4; i++) @(negedge clk);
    checks++;
    if (log_q.size() < 4) begin
      failures++; $display("FAIL both_log_size got=%0d exp>=4", log_q.size());
    end else begin
      checks += 6;
      if (log_q[0].data !== 8'hC0) begin failures++; $display("FAIL both_status got=%h exp=C0", log_q[0].data); end
      if (log_q[1].is_write || log_q[1].addr !== 5'h00 || log_q[1].data !== 8'h7E) begin
        failures++; $display("FAIL both_rx_rd got=%b/%h/%h exp=0/00/7E", log_q[1].is_write, log_q[1].addr, log_q[1].data); end
      if (!log_q[2].is_write || log_q[2].addr !== 5'h04 || log_q[2].data !== 8'h33) begin
        failures++; $display("FAIL both_wr got=%b/%h/%h exp=1/04/33", log_q[2].is_write, log_q[2].addr, log_q[2].data); end
      if (log_q[3].is_write || log_q[3].addr !== 5'h08) begin
        failures++; $display("FAIL both_next_poll got=%b/%h exp=0/08", log_q[3].is_write, log_q[3].addr); end
      if (log_q[3].start_cyc != log_q[2].acc_cyc) begin
        failures++; $display("FAIL both_no_gap got=%0d exp=%0d", log_q[3].start_cyc, log_q[2].acc_cyc); end
      if (rx_valid !== 1'b1 || rx_data !== 8'h7E) begin
        failures++; $display("FAIL both_rx_head got=%b/%h exp=1/7E", rx_valid, rx_data); end
    end
  endtask

  task automatic test_bus();
    int other;
    do_reset();
    rdv_delay = 5;
    repeat (3) @(negedge clk);
    spur_data = 8'hC8; spur_rdv = 1;
    @(negedge clk);
    spur_rdv = 0;
    for (int i = 0; i < 100 && log_q.size() < 1; i++) @(negedge clk);
    repeat (8) @(negedge clk);
    other = 0;
    foreach (log_q[i]) if (log_q[i].is_write || log_q[i].addr != 5'h08) other++;
    checks += 4;
    if (log_q.size() < 1 || log_q[0].data !== 8'h40) begin failures++; $display("FAIL bus_status got_n=%0d exp=1 with 40", log_q.size()); end
    if (other != 0) begin failures++; $display("FAIL bus_spurious_xfer got=%0d exp=0", other); end
    if (rx_overrun !== 1'b0) begin failures++; $display("FAIL bus_spurious_ovr got=%b exp=0", rx_overrun); end
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL bus_spurious_rx got=%b exp=0", rx_valid); end
    uart_rxq.push_back(8'h3C);
    for (int i = 0; i < 200 && !rx_valid; i++) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin failures++; $display("FAIL bus_delayed_rx got=%b/%h exp=1/3C", rx_valid, rx_data); end
    roe_en = 1;
    for (int i = 0; i < 150 && !rx_overrun; i++) @(negedge clk);
    checks++;
    if (rx_overrun !== 1'b1) begin failures++; $display("FAIL bus_roe got=%b exp=1", rx_overrun); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_tx [6];
    logic [7:0] exp_rx [6];
    logic [7:0] got_rx [$];
    logic [7:0] got_tx [$];
    int  tx_idx;
    bit  acc;
    int  nwr;
    bit  all_stable;
    do_reset();
    rand_bus = 1;
    for (int i = 0; i < 6; i++) begin
      exp_tx[i] = 8'($urandom);
      exp_rx[i] = 8'($urandom);
      uart_rxq.push_back(exp_rx[i]);
    end
    tx_idx = 0; acc = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (acc) tx_idx++;
      rx_ready = ($urandom_range(0, 3) != 0);
      if (rx_valid && rx_ready) got_rx.push_back(rx_data);
      if (tx_idx < 6 && $urandom_range(0, 1) == 1) begin
        tx_valid = 1; tx_data = exp_tx[tx_idx];
      end else begin
        tx_valid = 0;
      end
      acc = tx_valid && tx_ready;
      nwr = 0;
      foreach (log_q[i]) if (log_q[i].is_write) nwr++;
      if (nwr == 6 && got_rx.size() == 6) break;
    end
    tx_valid = 0; rx_ready = 0;
    all_stable = 1;
    foreach (log_q[i]) begin
      if (!log_q[i].stable) all_stable = 0;
      if (log_q[i].is_write) got_tx.push_back(log_q[i].data);
    end
    checks += 4;
    if (got_tx.size() != 6) begin failures++; $display("FAIL b2b_tx_count got=%0d exp=6", got_tx.size()); end
    if (got_rx.size() != 6) begin failures++; $display("FAIL b2b_rx_count got=%0d exp=6", got_rx.size()); end
    if (!all_stable) begin failures++; $display("FAIL b2b_stable got=0 exp=1"); end
    if (both_hi) begin failures++; $display("FAIL rd_wr_both got=1 exp=0"); end
    for (int i = 0; i < 6 && i < got_tx.size(); i++) begin
      checks++;
      if (got_tx[i] !== exp_tx[i]) begin failures++; $display("FAIL b2b_tx[%0d] got=%h exp=%h", i, got_tx[i], exp_tx[i]); end
    end
    for (int i = 0; i < 6 && i < got_rx.size(); i++) begin
      checks++;
      if (got_rx[i] !== exp_rx[i]) begin failures++; $display("FAIL b2b_rx[%0d] got=%h exp=%h", i, got_rx[i], exp_rx[i]); end
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    ws_wr = 20;
    uart_rxq.push_back(8'h11);
    tx_data = 8'h99; tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
    for (int i = 0; i < 120 && !avm_write; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks += 3;
    if (avm_write !== 1'b1 || waitreq !== 1'b1) begin failures++; $display("FAIL mid_wr_pending got=%b/%b exp=1/1", avm_write, waitreq); end
    if (rx_valid !== 1'b1) begin failures++; $display("FAIL mid_rx_before got=%b exp=1", rx_valid); end
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL mid_tx_before got=%b exp=0", tx_ready); end
    reset_n = 0;
    #1;
    checks += 4;
    if (avm_write !== 1'b0) begin failures++; $display("FAIL mid_rst_write got=%b exp=0", avm_write); end
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_tx_ready got=%b exp=1", tx_ready); end
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_rx_valid got=%b exp=0", rx_valid); end
    if (rx_data !== 8'h00) begin failures++; $display("FAIL mid_rst_rx_data got=%h exp=00", rx_data); end
    do_reset();
  endtask

  initial begin
    reset_n = 0; tx_valid = 0; tx_data = 0; rx_ready = 0;
    spur_rdv = 0; spur_data = 0;
    test_reset();
    test_tx();
    test_rx();
    test_both();
    test_bus();
    test_back_to_back();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
